dmem_rr_arbiter: RTL and testbench

//  Shares one data-memory port between num_req_p core-side requesters that use the
//  mem_in_s/mem_out_s valid/yumi protocol. Requests are granted round-robin, with one

---
 rtl/dmem_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory port among num_req_p valid/yumi requesters.
// One transaction in flight: IDLE picks a winner, ISSUE presents it, WAIT steers the response back.
module dmem_rr_arbiter #(
    parameter int num_req_p = 2,
    parameter int addr_w_p  = 32,
    parameter int data_w_p  = 32,
    localparam int idx_w    = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_req_p-1:0]           req_valid_i,
    input  logic [num_req_p-1:0]           req_wen_i,
    input  logic [num_req_p-1:0]           req_byte_i,
    input  logic [num_req_p*addr_w_p-1:0]  req_addr_i,
    input  logic [num_req_p*data_w_p-1:0]  req_wdata_i,
    output logic [num_req_p-1:0]           req_yumi_o,
    output logic [num_req_p-1:0]           resp_valid_o,
    output logic [data_w_p-1:0]            resp_data_o,
    input  logic [num_req_p-1:0]           resp_yumi_i,
    output logic                           mem_valid_o,
    output logic                           mem_wen_o,
    output logic                           mem_byte_o,
    output logic [addr_w_p-1:0]            mem_addr_o,
    output logic [data_w_p-1:0]            mem_wdata_o,
    input  logic                           mem_yumi_i,
    input  logic                           mem_resp_valid_i,
    input  logic [data_w_p-1:0]            mem_rdata_i,
    output logic                           mem_resp_yumi_o,
    output logic [idx_w-1:0]               grant_o,
    output logic                           busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [num_req_p-1:0] LANE0 = {{(num_req_p-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [idx_w-1:0]       r_grant;
    logic [idx_w-1:0]       r_last;

    logic [idx_w-1:0]       w_pick;
    logic                   w_any;
    logic [num_req_p-1:0]   w_lane;
    logic                   w_issue_hs;
    logic                   w_resp_hs;

    // Scan last+N down to last+1 so the lowest offset from last_r wins by overwriting.
    always_comb begin
        logic [idx_w-1:0] v_idx;
        v_idx  = '0;
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = num_req_p; k >= 1; k--) begin
            v_idx = idx_w'((int'(r_last) + k) % num_req_p);
            if (req_valid_i[v_idx]) begin
                w_pick = v_idx;
                w_any  = 1'b1;
            end
        end
    end

    assign w_lane     = LANE0 << r_grant;
    assign w_issue_hs = (r_state == ST_ISSUE) && req_valid_i[r_grant] && mem_yumi_i;
    assign w_resp_hs  = (r_state == ST_WAIT) && mem_resp_valid_i && resp_yumi_i[r_grant];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= idx_w'(num_req_p - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A withdrawn request leaves last_r alone so the lane keeps its turn.
                    if (!req_valid_i[r_grant]) begin
                        r_state <= ST_IDLE;
                    end else if (mem_yumi_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_resp_hs) begin
                        r_last  <= r_grant;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_valid_o = 1'b0;
        mem_wen_o   = 1'b0;
        mem_byte_o  = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (r_state == ST_ISSUE) begin
            mem_valid_o = req_valid_i[r_grant];
            mem_wen_o   = req_wen_i[r_grant];
            mem_byte_o  = req_byte_i[r_grant];
            mem_addr_o  = req_addr_i[r_grant*addr_w_p +: addr_w_p];
            mem_wdata_o = req_wdata_i[r_grant*data_w_p +: data_w_p];
        end
    end

    assign req_yumi_o      = w_issue_hs ? w_lane : '0;
    assign resp_valid_o    = ((r_state == ST_WAIT) && mem_resp_valid_i) ? w_lane : '0;
    assign resp_data_o     = (r_state == ST_WAIT) ? mem_rdata_i : '0;
    assign mem_resp_yumi_o = w_resp_hs;
    assign grant_o         = r_grant;
    assign busy_o          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter with four requesters and a hand-driven memory.
module tb_dmem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_wen_i = '0;
    logic [N-1:0]      req_byte_i = '0;
    logic [N*AW-1:0]   req_addr_i = '0;
    logic [N*DW-1:0]   req_wdata_i = '0;
    logic [N-1:0]      req_yumi_o;
    logic [N-1:0]      resp_valid_o;
    logic [DW-1:0]     resp_data_o;
    logic [N-1:0]      resp_yumi_i = '0;
    logic              mem_valid_o;
    logic              mem_wen_o;
    logic              mem_byte_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_yumi_i = 1'b0;
    logic              mem_resp_valid_i = 1'b0;
    logic [DW-1:0]     mem_rdata_i = '0;
    logic              mem_resp_yumi_o;
    logic [1:0]        grant_o;
    logic              busy_o;

    int                n_total = 0;
    int                n_bad = 0;
    logic [1:0]        exp_q[$];

    dmem_rr_arbiter #(.num_req_p(N), .addr_w_p(AW), .data_w_p(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_yumi_o(req_yumi_o),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_i(mem_yumi_i),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i),
        .mem_resp_yumi_o(mem_resp_yumi_o), .grant_o(grant_o), .busy_o(busy_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: drive just after the rising edge, check before the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid_i = '0;
        req_wen_i = '0;
        req_byte_i = '0;
        resp_yumi_i = '0;
        mem_yumi_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_default_addrs();
        for (int r = 0; r < N; r++) begin
            req_addr_i[r*AW +: AW]  = 32'h100 + 32'(r * 16);
            req_wdata_i[r*DW +: DW] = 32'hA000 + 32'(r);
        end
    endtask

    // Memory side of one zero-wait transaction for the expected lane.
    task automatic serve(input logic [1:0] exp_g, input logic [31:0] rdata);
        int n;
        n = 0;
        settle();
        while (!mem_valid_o && n < 10) begin
            tick();
            settle();
            n++;
        end
        if (n >= 10) begin
            chk("serve_timeout", 64'(n), 64'(0));
        end else begin
            chk("serve_grant", grant_o, exp_g);
            chk("serve_addr", mem_addr_o, 32'h100 + 32'(exp_g) * 16);
            mem_yumi_i = 1'b1;
            settle();
            chk("serve_req_yumi", req_yumi_o, 4'b0001 << exp_g);
            tick();
            mem_yumi_i = 1'b0;
            mem_resp_valid_i = 1'b1;
            mem_rdata_i = rdata;
            settle();
            chk("serve_resp_valid", resp_valid_o, 4'b0001 << exp_g);
            chk("serve_resp_data", resp_data_o, rdata);
            chk("serve_mem_resp_yumi", mem_resp_yumi_o, 1'b1);
            tick();
            mem_resp_valid_i = 1'b0;
        end
    endtask

    initial begin
        // Test 1: idle after reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t1_mem_valid", mem_valid_o, 1'b0);
            chk("t1_req_yumi", req_yumi_o, 4'b0);
            chk("t1_resp_valid", {resp_valid_o, resp_data_o}, 36'h0);
            chk("t1_mem_fields", {mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o}, 66'h0);
            chk("t1_grant_busy", {grant_o, busy_o, mem_resp_yumi_o}, 4'b0);
            tick();
        end

        // Test 2: single load from requester 0
        do_reset();
        req_addr_i[0 +: AW] = 32'h10;
        req_valid_i = 4'b0001;
        tick();
        settle();
        chk("t2_mem_valid", mem_valid_o, 1'b1);
        chk("t2_mem_addr", mem_addr_o, 32'h10);
        chk("t2_mem_wen", mem_wen_o, 1'b0);
        chk("t2_busy", busy_o, 1'b1);
        mem_yumi_i = 1'b1;
        settle();
        chk("t2_req_yumi", req_yumi_o, 4'b0001);
        tick();
        req_valid_i = '0;
        mem_yumi_i = 1'b0;
        settle();
        chk("t2_no_resp_yet", resp_valid_o, 4'b0);
        chk("t2_mem_valid_wait", mem_valid_o, 1'b0);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        settle();
        chk("t2_resp_valid", resp_valid_o, 4'b0001);
        chk("t2_resp_data", resp_data_o, 32'hDEADBEEF);
        chk("t2_resp_yumi_hold", mem_resp_yumi_o, 1'b0);
        tick();
        resp_yumi_i = 4'b0001;
        settle();
        chk("t2_resp_yumi", mem_resp_yumi_o, 1'b1);
        tick();
        mem_resp_valid_i = 1'b0;
        resp_yumi_i = '0;
        settle();
        chk("t2_idle", busy_o, 1'b0);

        // Test 3: two lanes held valid alternate
        do_reset();
        set_default_addrs();
        req_valid_i = 4'b0011;
        resp_yumi_i = 4'b1111;
        for (int i = 0; i < 6; i++) exp_q.push_back(2'(i % 2));
        for (int i = 0; i < 6; i++) serve(exp_q.pop_front(), 32'h5000 + 32'(i));
        req_valid_i = '0;

        // Test 4: wrap from lane 3 to lane 0, then full rotation
        do_reset();
        set_default_addrs();
        resp_yumi_i = 4'b1111;
        req_valid_i = 4'b1000;
        serve(2'd3, 32'h33);
        req_valid_i = 4'b0001;
        serve(2'd0, 32'h00);
        req_valid_i = 4'b1000;
        serve(2'd3, 32'h33);
        req_valid_i = 4'b1111;
        serve(2'd0, 32'h40);
        serve(2'd1, 32'h41);
        serve(2'd2, 32'h42);
        serve(2'd3, 32'h43);
        req_valid_i = '0;

        // Test 5: store held off by memory, then withdrawn
        do_reset();
        set_default_addrs();
        req_addr_i[1*AW +: AW] = 32'h40;
        req_wdata_i[1*DW +: DW] = 32'h12345678;
        req_wen_i = 4'b0010;
        req_byte_i = 4'b0010;
        req_valid_i = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t5_mem_valid", mem_valid_o, 1'b1);
            chk("t5_fields", {mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o},
                {1'b1, 1'b1, 32'h40, 32'h12345678});
            chk("t5_no_yumi", req_yumi_o, 4'b0);
            tick();
        end
        req_valid_i = '0;
        mem_yumi_i = 1'b1;
        settle();
        chk("t5_drop_valid", mem_valid_o, 1'b0);
        chk("t5_drop_yumi", req_yumi_o, 4'b0);
        tick();
        mem_yumi_i = 1'b0;
        req_wen_i = '0;
        req_byte_i = '0;
        settle();
        chk("t5_back_idle", {busy_o, grant_o}, 3'b001);
        set_default_addrs();
        resp_yumi_i = 4'b1111;
        req_valid_i = 4'b0110;
        serve(2'd1, 32'h77);
        req_valid_i = '0;

        // Test 6: reset during WAIT drops the transaction
        do_reset();
        set_default_addrs();
        resp_yumi_i = 4'b0001;
        req_valid_i = 4'b0001;
        tick();
        mem_yumi_i = 1'b1;
        tick();
        mem_yumi_i = 1'b0;
        req_valid_i = '0;
        settle();
        chk("t6_in_wait", busy_o, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("t6_state", {busy_o, grant_o, mem_valid_o}, 4'b0);
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t6_resp_valid", resp_valid_o, 4'b0);
            chk("t6_resp_yumi", mem_resp_yumi_o, 1'b0);
            chk("t6_resp_data", resp_data_o, 32'h0);
            tick();
        end
        mem_resp_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
